// File: rtl/imm_gen_pipe.sv
// Registered RV immediate generator behind a 2-entry skid buffer (valid/ready in and out).
// Optional macro IMM_GEN_BYTE_OFFSET_EN: B/J immediates become byte offsets instead of halfword units.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_J     = 3'd4;
    localparam logic [2:0] FMT_U     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Every format fits in 32 signed bits; widening to XLEN is a plain sign extension.
    function automatic logic signed [XLEN-1:0] sext_xlen(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    logic [6:0]              opcode;
    logic [2:0]              funct3;
    logic signed [31:0]      imm32_p0;
    logic signed [XLEN-1:0]  imm_p0;
    logic [2:0]              fmt_p0;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    // Stage p0: combinational decode of the offered instruction
    always_comb begin
        imm32_p0 = '0;
        fmt_p0   = FMT_NONE;
        case (opcode)
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    fmt_p0   = FMT_SHAMT;
                    imm32_p0 = (XLEN == 64) ? {26'b0, in_instr[25:20]}
                                            : {27'b0, in_instr[24:20]};
                end else begin
                    fmt_p0   = FMT_I;
                    imm32_p0 = {{20{in_instr[31]}}, in_instr[31:20]};
                end
            end
            7'b0000011, 7'b1100111: begin
                fmt_p0   = FMT_I;
                imm32_p0 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                fmt_p0   = FMT_S;
                imm32_p0 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                fmt_p0   = FMT_B;
`ifdef IMM_GEN_BYTE_OFFSET_EN
                imm32_p0 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
`else
                imm32_p0 = {{20{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8]};
`endif
            end
            7'b1101111: begin
                fmt_p0   = FMT_J;
`ifdef IMM_GEN_BYTE_OFFSET_EN
                imm32_p0 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
`else
                imm32_p0 = {{12{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21]};
`endif
            end
            7'b0110111, 7'b0010111: begin
                fmt_p0   = FMT_U;
                imm32_p0 = {in_instr[31:12], 12'b0};
            end
            default: ;
        endcase
    end

    assign imm_p0 = sext_xlen(imm32_p0);

    logic push, pop;
    logic load_main, load_skid, move_skid;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // Occupancy FSM; flush overrides everything including a same-cycle push
    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_main = 1'b1;
                end else if (push) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt = ONE;
                    move_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
            move_skid = 1'b0;
        end
    end

    logic [XLEN-1:0]  main_imm_p1, skid_imm_p1;
    logic [2:0]       main_fmt_p1, skid_fmt_p1;
    logic [TAG_W-1:0] main_tag_p1, skid_tag_p1;

    // Stage p1: main (visible) and skid entries; cleared on reset and flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_imm_p1 <= '0;
            main_fmt_p1 <= '0;
            main_tag_p1 <= '0;
            skid_imm_p1 <= '0;
            skid_fmt_p1 <= '0;
            skid_tag_p1 <= '0;
        end else if (flush) begin
            main_imm_p1 <= '0;
            main_fmt_p1 <= '0;
            main_tag_p1 <= '0;
            skid_imm_p1 <= '0;
            skid_fmt_p1 <= '0;
            skid_tag_p1 <= '0;
        end else begin
            if (load_main) begin
                main_imm_p1 <= imm_p0;
                main_fmt_p1 <= fmt_p0;
                main_tag_p1 <= in_tag;
            end else if (move_skid) begin
                main_imm_p1 <= skid_imm_p1;
                main_fmt_p1 <= skid_fmt_p1;
                main_tag_p1 <= skid_tag_p1;
            end
            if (load_skid) begin
                skid_imm_p1 <= imm_p0;
                skid_fmt_p1 <= fmt_p0;
                skid_tag_p1 <= in_tag;
            end
        end
    end

    assign out_imm = main_imm_p1;
    assign out_fmt = main_fmt_p1;
    assign out_tag = main_tag_p1;

endmodule
